// File: rtl/htpa_roi_expand.sv
// ROI box expander: widens each detector box by a per-axis gap, clamps it to the
// sensor frame, and tags it with a per-frame index through a two-stage pipeline.
module htpa_roi_expand #(
    parameter int XW      = 7,
    parameter int YW      = 6,
    parameter int GW      = 2,
    parameter int X_MAX   = 127,
    parameter int Y_MAX   = 63,
    parameter int MAX_ROI = 16,
    localparam int IW     = $clog2(MAX_ROI)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sof_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [XW-1:0] in_xo_i,
    input  logic [XW-1:0] in_xn_i,
    input  logic [YW-1:0] in_yo_i,
    input  logic [YW-1:0] in_yn_i,
    input  logic [GW-1:0] cfg_gap_x_i,
    input  logic [GW-1:0] cfg_gap_y_i,
    input  logic          cfg_bypass_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [XW-1:0] out_xo_o,
    output logic [XW-1:0] out_xn_o,
    output logic [YW-1:0] out_yo_o,
    output logic [YW-1:0] out_yn_o,
    output logic [IW-1:0] out_idx_o,
    output logic [3:0]    out_clamp_o,
    output logic          out_bad_o,
    output logic          ovf_o
);
    localparam logic [XW-1:0] X_LIM    = XW'(X_MAX);
    localparam logic [YW-1:0] Y_LIM    = YW'(Y_MAX);
    localparam logic [IW:0]   CNT_FULL = (IW+1)'(MAX_ROI);

    logic          rdy_en_q;
    logic [IW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          s1_valid_q;
    logic [XW-1:0] s1_xo_q, s1_xn_q;
    logic [YW-1:0] s1_yo_q, s1_yn_q;
    logic [GW-1:0] s1_gx_q, s1_gy_q;
    logic [IW-1:0] s1_idx_q;
    logic          out_valid_q;
    logic [XW-1:0] out_xo_q, out_xn_q;
    logic [YW-1:0] out_yo_q, out_yn_q;
    logic [IW-1:0] out_idx_q;
    logic [3:0]    out_clamp_q;
    logic          out_bad_q;

    logic          s2_load, accept, drop, s1_take;
    logic [XW-1:0] xo_c, xo_e, xn_e;
    logic [YW-1:0] yo_c, yo_e, yn_e;
    logic [XW:0]   x_sum;
    logic [YW:0]   y_sum;
    logic          s1_bad;
    logic [3:0]    clamp_e;

    assign s2_load    = !out_valid_q || out_ready_i;
    assign in_ready_o = rdy_en_q && (!s1_valid_q || s2_load);
    assign accept     = in_valid_i && in_ready_o;
    // A full frame swallows further boxes without stalling upstream.
    assign drop       = accept && !sof_i && (cnt_q == CNT_FULL);
    assign s1_take    = accept && !drop;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (sof_i) begin
            cnt_d = accept ? (IW+1)'(1) : '0;
            ovf_d = 1'b0;
        end else if (accept) begin
            if (cnt_q == CNT_FULL) ovf_d = 1'b1;
            else                   cnt_d = cnt_q + (IW+1)'(1);
        end
    end

    always_comb begin
        clamp_e = '0;
        s1_bad  = (s1_xo_q > s1_xn_q) || (s1_yo_q > s1_yn_q);
        xo_c    = ({1'b0, s1_xo_q} > {1'b0, X_LIM}) ? X_LIM : s1_xo_q;
        yo_c    = ({1'b0, s1_yo_q} > {1'b0, Y_LIM}) ? Y_LIM : s1_yo_q;
        x_sum   = {1'b0, s1_xn_q} + (XW+1)'(s1_gx_q);
        y_sum   = {1'b0, s1_yn_q} + (YW+1)'(s1_gy_q);
        clamp_e[3] = x_sum > {1'b0, X_LIM};
        clamp_e[2] = XW'(s1_gx_q) > xo_c;
        clamp_e[1] = y_sum > {1'b0, Y_LIM};
        clamp_e[0] = YW'(s1_gy_q) > yo_c;
        xn_e = clamp_e[3] ? X_LIM : x_sum[XW-1:0];
        xo_e = clamp_e[2] ? '0 : xo_c - XW'(s1_gx_q);
        yn_e = clamp_e[1] ? Y_LIM : y_sum[YW-1:0];
        yo_e = clamp_e[0] ? '0 : yo_c - YW'(s1_gy_q);
        // Malformed boxes travel untouched so readout can inspect the raw corners.
        if (s1_bad) begin
            xo_e    = s1_xo_q;
            xn_e    = s1_xn_q;
            yo_e    = s1_yo_q;
            yn_e    = s1_yn_q;
            clamp_e = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en_q    <= 1'b0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_xo_q     <= '0;
            s1_xn_q     <= '0;
            s1_yo_q     <= '0;
            s1_yn_q     <= '0;
            s1_gx_q     <= '0;
            s1_gy_q     <= '0;
            s1_idx_q    <= '0;
            out_valid_q <= 1'b0;
            out_xo_q    <= '0;
            out_xn_q    <= '0;
            out_yo_q    <= '0;
            out_yn_q    <= '0;
            out_idx_q   <= '0;
            out_clamp_q <= '0;
            out_bad_q   <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            if (in_ready_o) begin
                s1_valid_q <= s1_take;
                if (s1_take) begin
                    s1_xo_q  <= in_xo_i;
                    s1_xn_q  <= in_xn_i;
                    s1_yo_q  <= in_yo_i;
                    s1_yn_q  <= in_yn_i;
                    s1_gx_q  <= cfg_bypass_i ? '0 : cfg_gap_x_i;
                    s1_gy_q  <= cfg_bypass_i ? '0 : cfg_gap_y_i;
                    s1_idx_q <= sof_i ? '0 : cnt_q[IW-1:0];
                end
            end
            if (s2_load) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_xo_q    <= xo_e;
                    out_xn_q    <= xn_e;
                    out_yo_q    <= yo_e;
                    out_yn_q    <= yn_e;
                    out_idx_q   <= s1_idx_q;
                    out_clamp_q <= clamp_e;
                    out_bad_q   <= s1_bad;
                end
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_xo_o    = out_xo_q;
    assign out_xn_o    = out_xn_q;
    assign out_yo_o    = out_yo_q;
    assign out_yn_o    = out_yn_q;
    assign out_idx_o   = out_idx_q;
    assign out_clamp_o = out_clamp_q;
    assign out_bad_o   = out_bad_q;
    assign ovf_o       = ovf_q;
endmodule

// File: tb/tb_htpa_roi_expand.sv
// Bench for htpa_roi_expand: directed steps plus random boxes, scored against an
// arithmetic model of box expansion, per-frame indexing and overflow.
module tb_htpa_roi_expand;
    localparam int XW = 7, YW = 6, GW = 2, XMAX = 127, YMAX = 63, MAXR = 16, IW = 4;

    logic          clk = 1'b0, rst = 1'b1, sof = 1'b0, in_valid = 1'b0;
    logic          out_ready = 1'b1, bypass = 1'b0;
    logic [XW-1:0] in_xo = '0, in_xn = '0;
    logic [YW-1:0] in_yo = '0, in_yn = '0;
    logic [GW-1:0] gap_x = '0, gap_y = '0;
    logic          in_ready_o, out_valid_o, out_bad_o, ovf_o;
    logic [XW-1:0] out_xo_o, out_xn_o;
    logic [YW-1:0] out_yo_o, out_yn_o;
    logic [IW-1:0] out_idx_o;
    logic [3:0]    out_clamp_o;

    int         checks = 0, errors = 0;
    logic [34:0] exp_q[$];
    int         m_cnt = 0;
    bit         m_ovf = 0, hold = 0, rand_ready = 0;
    logic [34:0] held = '0;
    wire  [34:0] out_vec = {out_xo_o, out_xn_o, out_yo_o, out_yn_o, out_idx_o, out_clamp_o, out_bad_o};

    htpa_roi_expand dut (
        .clk(clk), .rst(rst), .sof_i(sof), .in_valid_i(in_valid), .in_ready_o(in_ready_o),
        .in_xo_i(in_xo), .in_xn_i(in_xn), .in_yo_i(in_yo), .in_yn_i(in_yn),
        .cfg_gap_x_i(gap_x), .cfg_gap_y_i(gap_y), .cfg_bypass_i(bypass),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready),
        .out_xo_o(out_xo_o), .out_xn_o(out_xn_o), .out_yo_o(out_yo_o), .out_yn_o(out_yn_o),
        .out_idx_o(out_idx_o), .out_clamp_o(out_clamp_o), .out_bad_o(out_bad_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Expected output word: expand by gap, saturate at 0 and at the frame limit.
    function automatic logic [34:0] ref_box(input int xo, xn, yo, yn, gxc, gyc,
                                            input bit byp, input int idx);
        int gx, gy, rxo, rxn, ryo, ryn;
        logic [3:0] cl;
        gx = byp ? 0 : gxc;
        gy = byp ? 0 : gyc;
        cl = 4'b0000;
        if (xo > xn || yo > yn)
            return {XW'(xo), XW'(xn), YW'(yo), YW'(yn), IW'(idx), 4'b0000, 1'b1};
        rxo = (xo > XMAX ? XMAX : xo) - gx;
        if (rxo < 0) begin rxo = 0; cl[2] = 1'b1; end
        rxn = xn + gx;
        if (rxn > XMAX) begin rxn = XMAX; cl[3] = 1'b1; end
        ryo = (yo > YMAX ? YMAX : yo) - gy;
        if (ryo < 0) begin ryo = 0; cl[0] = 1'b1; end
        ryn = yn + gy;
        if (ryn > YMAX) begin ryn = YMAX; cl[1] = 1'b1; end
        return {XW'(rxo), XW'(rxn), YW'(ryo), YW'(ryn), IW'(idx), cl, 1'b0};
    endfunction

    // Scoreboard and frame model, evaluated mid-cycle for the coming edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_cnt = 0;
            m_ovf = 0;
            hold  = 0;
        end else begin
            chk("ovf", 35'(ovf_o), 35'(m_ovf));
            if (hold) begin
                chk("hold_valid", 35'(out_valid_o), 35'd1);
                chk("hold_data", out_vec, held);
            end
            if (out_valid_o && out_ready) begin
                $display("out idx=%0d box=(%0d,%0d,%0d,%0d) clamp=%b bad=%b",
                         out_idx_o, out_xo_o, out_xn_o, out_yo_o, out_yn_o, out_clamp_o, out_bad_o);
                if (exp_q.size() == 0) chk("unexpected_out", 35'(exp_q.size()), 35'd1);
                else                   chk("out_box", out_vec, exp_q.pop_front());
            end
            hold = out_valid_o && !out_ready;
            held = out_vec;
            if (in_valid && in_ready_o) begin
                if (sof) begin
                    exp_q.push_back(ref_box(in_xo, in_xn, in_yo, in_yn, gap_x, gap_y, bypass, 0));
                    m_cnt = 1;
                    m_ovf = 0;
                end else if (m_cnt == MAXR) begin
                    m_ovf = 1;
                end else begin
                    exp_q.push_back(ref_box(in_xo, in_xn, in_yo, in_yn, gap_x, gap_y, bypass, m_cnt));
                    m_cnt++;
                end
            end else if (sof) begin
                m_cnt = 0;
                m_ovf = 0;
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int xo, xn, yo, yn, input bit s);
        bit done;
        done  = 0;
        in_xo = XW'(xo); in_xn = XW'(xn); in_yo = YW'(yo); in_yn = YW'(yn);
        in_valid = 1'b1;
        sof = s;
        for (int k = 0; k < 64 && !done; k++) begin
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            done = in_ready_o;
            @(posedge clk); #1;
            sof = 1'b0;
        end
        in_valid = 1'b0;
        chk("accept_timeout", 35'(done), 35'd1);
    endtask

    task automatic check_after2(input string tag, input logic [34:0] expv);
        @(negedge clk);
        chk({tag, "_lat1"}, 35'(out_valid_o), 35'd0);
        @(negedge clk);
        chk({tag, "_lat2"}, 35'(out_valid_o), 35'd1);
        chk(tag, out_vec, expv);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        chk("drain", 35'(exp_q.size()), 35'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 35'(out_valid_o), 35'd0);
        chk("rst_ready", 35'(in_ready_o), 35'd0);
        chk("rst_data", out_vec, 35'd0);
        chk("rst_ovf", 35'(ovf_o), 35'd0);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("ready_pre", 35'(in_ready_o), 35'd0);
        @(posedge clk); #1;
        chk("ready_post", 35'(in_ready_o), 35'd1);

        gap_x = 2'd2; gap_y = 2'd1;
        send(10, 20, 5, 9, 1'b1);
        check_after2("default_box", {7'd8, 7'd22, 6'd4, 6'd10, 4'd0, 4'b0000, 1'b0});
        gap_x = 2'd3; gap_y = 2'd3;
        send(1, 126, 0, 63, 1'b0);
        check_after2("edge_box", {7'd0, 7'd127, 6'd0, 6'd63, 4'd1, 4'b1111, 1'b0});
        bypass = 1'b1;
        send(1, 126, 0, 63, 1'b0);
        check_after2("bypass_box", {7'd1, 7'd126, 6'd0, 6'd63, 4'd2, 4'b0000, 1'b0});
        bypass = 1'b0; gap_x = 2'd2; gap_y = 2'd1;
        send(30, 20, 5, 9, 1'b0);
        check_after2("bad_box", {7'd30, 7'd20, 6'd5, 6'd9, 4'd3, 4'b0000, 1'b1});
        send(10, 20, 5, 9, 1'b0);
        check_after2("after_bad", {7'd8, 7'd22, 6'd4, 6'd10, 4'd4, 4'b0000, 1'b0});

        // Burst with a downstream stall.
        gap_x = 2'd1; gap_y = 2'd1;
        out_ready = 1'b0;
        send(0, 5, 0, 2, 1'b1);
        send(10, 15, 1, 3, 1'b0);
        #1;
        chk("burst_stall", 35'(in_ready_o), 35'd0);
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 2; i < 5; i++) send(i * 10, i * 10 + 5, i, i + 2, 1'b0);
        drain();

        // Frame overflow and recovery on the next start-of-frame.
        gap_x = 2'd1; gap_y = 2'd2;
        for (int i = 0; i < 18; i++) begin
            send(i + 1, i + 4, i, i + 3, i == 0);
            if (i == 15) chk("ovf_before", 35'(ovf_o), 35'd0);
            if (i == 16) chk("ovf_set", 35'(ovf_o), 35'd1);
            if (i == 17) chk("ovf_sticky", 35'(ovf_o), 35'd1);
        end
        drain();
        chk("ovf_held", 35'(ovf_o), 35'd1);
        gap_x = 2'd2; gap_y = 2'd1;
        send(10, 20, 5, 9, 1'b1);
        chk("ovf_clear", 35'(ovf_o), 35'd0);
        check_after2("sof_box", {7'd8, 7'd22, 6'd4, 6'd10, 4'd0, 4'b0000, 1'b0});

        // Asynchronous reset with two boxes in flight.
        send(40, 50, 10, 20, 1'b0);
        send(41, 51, 11, 21, 1'b0);
        #1;
        chk("pre_rst_valid", 35'(out_valid_o), 35'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 35'(out_valid_o), 35'd0);
        chk("async_rst_ovf", 35'(ovf_o), 35'd0);
        chk("async_rst_ready", 35'(in_ready_o), 35'd0);
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        send(10, 20, 5, 9, 1'b0);
        check_after2("post_rst_box", {7'd8, 7'd22, 6'd4, 6'd10, 4'd0, 4'b0000, 1'b0});

        // Random boxes, configs, frame starts and downstream backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            int a, b, c, d;
            a = $urandom_range(0, XMAX); b = $urandom_range(0, XMAX);
            c = $urandom_range(0, YMAX); d = $urandom_range(0, YMAX);
            if ($urandom_range(0, 4) != 0) begin
                if (a > b) begin int t; t = a; a = b; b = t; end
                if (c > d) begin int t; t = c; c = d; d = t; end
            end
            gap_x  = GW'($urandom_range(0, 3));
            gap_y  = GW'($urandom_range(0, 3));
            bypass = ($urandom_range(0, 3) == 0);
            send(a, b, c, d, $urandom_range(0, 9) == 0);
            repeat ($urandom_range(0, 2)) begin
                out_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
            end
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
